serial_tl_arbiter: RTL and testbench
====================================

SERIAL_TL_ARBITER -- requirements
Module: serial_tl_arbiter

Interface
REQ-001 Parameter: OWNER_DEPTH, default 4, sets the owner-FIFO depth (outstanding request packets); power of two, 2..8.
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous assert, active-low; clears all state.
REQ-004 reqN_valid / reqN_ready  in/out  1  request beat handshake, N=0,1.
REQ-005 reqN_bits  in  32  request beat payload.
REQ-006 reqN_last  in  1  marks final beat of the request packet.
REQ-007 reqN_rlen  in  4  response beat count minus 1; valid with first beat.
REQ-008 respN_valid / respN_ready  out/in  1  response beat handshake, N=0,1.
REQ-009 respN_bits  out  32  response beat payload.
REQ-010 respN_last  out  1  marks final response beat.
REQ-011 tl_in_valid / tl_in_ready  out/in  1  beat handshake toward ChipTop serial_tl_bits_in.
REQ-012 tl_in_bits  out  32  drives ChipTop serial_tl_bits_in_bits.
REQ-013 tl_out_valid / tl_out_ready  in/out  1  beat handshake from ChipTop serial_tl_bits_out.
REQ-014 tl_out_bits  in  32  from ChipTop serial_tl_bits_out_bits.
REQ-015 busy  out  1  high when state != IDLE or owner FIFO non-empty.
REQ-016 outstanding  out  4  owner-FIFO occupancy, 0..OWNER_DEPTH.

Function
REQ-017 Request FSM states: IDLE, GRANT0, GRANT1; a handshake is valid && ready in the same cycle.
REQ-018 IDLE: if FIFO not full and any reqN_valid, grant one requester; next state GRANTN; else stay.
REQ-019 Round-robin: the requester not granted last has priority; after reset req0 has priority.
REQ-020 On the IDLE->GRANTN edge, push {owner=N, rlen=reqN_rlen} into the owner FIFO; no request beat transfers in the grant cycle.
REQ-021 GRANTN: tl_in_valid=reqN_valid, tl_in_bits=reqN_bits, reqN_ready=tl_in_ready (combinational); the other requester's ready = 0.
REQ-022 In IDLE, tl_in_valid=0 and both reqN_ready=0.
REQ-023 A reqN_last handshake in GRANTN returns the FSM to IDLE next cycle and records N as last winner; packets are never interleaved.
REQ-024 With FIFO full, IDLE holds with no grant until a pop frees an entry; an in-progress GRANT packet always completes.
REQ-025 Response path: with FIFO empty, tl_out_ready=0 and both respN_valid=0.
REQ-026 With FIFO non-empty, head owner H: respH_valid=tl_out_valid, respH_bits=tl_out_bits, tl_out_ready=respH_ready; other resp valid=0.
REQ-027 A 4-bit beat counter starts at 0, increments per tl_out handshake; respH_last=1 when counter==head rlen.
REQ-028 On the last-beat handshake, pop the head and clear the counter to 0.
REQ-029 Simultaneous push and pop in one cycle are both honoured; occupancy unchanged.
REQ-030 The FIFO read and write pointers wrap modulo OWNER_DEPTH; full = occupancy==OWNER_DEPTH.
REQ-031 Responses are routed strictly in request-grant order.

Reset
REQ-032 On reset_n low, asynchronously and in the same cycle: FSM=IDLE, last winner=req1 (req0 priority), FIFO empty, pointers=0, counter=0.
REQ-033 During reset: all outputs valid/ready=0, busy=0, outstanding=0; tl_in_bits and respN_bits = 0.
REQ-034 Reset mid-packet abandons all in-flight beats; no recovery state is retained.

Verification
REQ-035 req0 sends 3 beats (0xA0,0xA1,0xA2 last, rlen=1), tl_in_ready=1 -> grant at cycle 1, beats on tl_in in cycles 2-4; two tl_out beats route to resp0, last on the 2nd; outstanding 1->0.
REQ-036 req0 and req1 both valid in IDLE after reset -> req0 granted first, req1 granted after req0's last beat; next contention grants req0.
REQ-037 OWNER_DEPTH=4, four 1-beat requests with no responses -> outstanding=4 and a fifth stays ungranted; one 1-beat response (rlen=0) -> pop, and the fifth is granted next cycle.
REQ-038 Push and pop in the same cycle at occupancy 2 -> outstanding stays 2; order req1,req0 -> responses go to resp1, then resp0.
REQ-039 resp0_ready low for 5 cycles during response beat 2 of 4 -> tl_out_ready low, counter held at 1, no beat lost or duplicated.
REQ-040 reset_n pulsed low mid-GRANT1 packet -> outputs 0 immediately, outstanding=0; after release, req0 wins the first contention.

Source files
------------

// File: rtl/serial_tl_arbiter.sv
// Two-requester arbiter in front of a ChipTop serial TileLink port. It grants whole request
// packets round-robin and steers response beats back in grant order through an owner FIFO.
module serial_tl_arbiter #(
  parameter int unsigned OWNER_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_bits,
  input  logic        req0_last,
  input  logic [3:0]  req0_rlen,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_bits,
  input  logic        req1_last,
  input  logic [3:0]  req1_rlen,

  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_bits,
  output logic        resp0_last,

  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_bits,
  output logic        resp1_last,

  output logic        tl_in_valid,
  input  logic        tl_in_ready,
  output logic [31:0] tl_in_bits,

  input  logic        tl_out_valid,
  output logic        tl_out_ready,
  input  logic [31:0] tl_out_bits,

  output logic        busy,
  output logic [3:0]  outstanding
);

  localparam int unsigned PtrW = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   r_last_winner;
  logic                   w_last_winner_next;

  logic [OWNER_DEPTH-1:0] r_fifo_owner;
  logic [3:0]             r_fifo_rlen [OWNER_DEPTH];
  logic [PtrW-1:0]        r_wptr;
  logic [PtrW-1:0]        r_rptr;
  logic [3:0]             r_count;
  logic [3:0]             r_beat;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_push_owner;
  logic [3:0]             w_push_rlen;
  logic                   w_pop;
  logic                   w_beat_fire;
  logic                   w_head_owner;
  logic [3:0]             w_head_rlen;
  logic                   w_last_beat;

  assign w_full       = (r_count == 4'(OWNER_DEPTH));
  assign w_empty      = (r_count == 4'd0);
  assign w_head_owner = r_fifo_owner[r_rptr];
  assign w_head_rlen  = r_fifo_rlen[r_rptr];
  assign w_last_beat  = (r_beat == w_head_rlen);

  assign busy        = (r_state != StIdle) || !w_empty;
  assign outstanding = r_count;

  // Request side: the grant cycle only pushes ownership; beats flow from the next cycle on.
  always_comb begin
    w_state_next       = r_state;
    w_last_winner_next = r_last_winner;
    w_push             = 1'b0;
    w_push_owner       = 1'b0;
    w_push_rlen        = 4'd0;
    tl_in_valid        = 1'b0;
    tl_in_bits         = 32'd0;
    req0_ready         = 1'b0;
    req1_ready         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (!w_full && (req0_valid || req1_valid)) begin
          w_push = 1'b1;
          // r_last_winner high means req1 went last, so req0 holds priority.
          if (req0_valid && (!req1_valid || r_last_winner)) begin
            w_push_owner = 1'b0;
            w_push_rlen  = req0_rlen;
            w_state_next = StGrant0;
          end else begin
            w_push_owner = 1'b1;
            w_push_rlen  = req1_rlen;
            w_state_next = StGrant1;
          end
        end
      end
      StGrant0: begin
        tl_in_valid = req0_valid;
        tl_in_bits  = req0_bits;
        req0_ready  = tl_in_ready;
        if (req0_valid && tl_in_ready && req0_last) begin
          w_state_next       = StIdle;
          w_last_winner_next = 1'b0;
        end
      end
      StGrant1: begin
        tl_in_valid = req1_valid;
        tl_in_bits  = req1_bits;
        req1_ready  = tl_in_ready;
        if (req1_valid && tl_in_ready && req1_last) begin
          w_state_next       = StIdle;
          w_last_winner_next = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Response side: the FIFO head decides which responder sees tl_out.
  always_comb begin
    resp0_valid  = 1'b0;
    resp0_bits   = 32'd0;
    resp0_last   = 1'b0;
    resp1_valid  = 1'b0;
    resp1_bits   = 32'd0;
    resp1_last   = 1'b0;
    tl_out_ready = 1'b0;
    w_beat_fire  = 1'b0;
    w_pop        = 1'b0;

    if (!w_empty) begin
      if (!w_head_owner) begin
        resp0_valid  = tl_out_valid;
        resp0_bits   = tl_out_bits;
        resp0_last   = w_last_beat;
        tl_out_ready = resp0_ready;
      end else begin
        resp1_valid  = tl_out_valid;
        resp1_bits   = tl_out_bits;
        resp1_last   = w_last_beat;
        tl_out_ready = resp1_ready;
      end
      w_beat_fire = tl_out_valid && tl_out_ready;
      w_pop       = w_beat_fire && w_last_beat;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_last_winner <= 1'b1;
      r_fifo_owner  <= '0;
      for (int unsigned i = 0; i < OWNER_DEPTH; i++) begin
        r_fifo_rlen[i] <= 4'd0;
      end
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= 4'd0;
      r_beat        <= 4'd0;
    end else begin
      r_state       <= w_state_next;
      r_last_winner <= w_last_winner_next;

      if (w_push) begin
        r_fifo_owner[r_wptr] <= w_push_owner;
        r_fifo_rlen[r_wptr]  <= w_push_rlen;
        r_wptr               <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_beat <= 4'd0;
      end else if (w_beat_fire) begin
        r_beat <= r_beat + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tl_arbiter.sv
// Scoreboard bench for serial_tl_arbiter: expected tl_in and response beats are queued as
// stimulus is loaded, and compared against beats captured from the DUT handshakes.
module tb_serial_tl_arbiter;

  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [31:0] bits;
    logic        last;
    logic [3:0]  rlen;
  } beat_t;

  logic        clock;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_last;
  logic [31:0] req0_bits;
  logic [3:0]  req0_rlen;
  logic        req1_valid, req1_ready, req1_last;
  logic [31:0] req1_bits;
  logic [3:0]  req1_rlen;
  logic        resp0_valid, resp0_ready, resp0_last;
  logic [31:0] resp0_bits;
  logic        resp1_valid, resp1_ready, resp1_last;
  logic [31:0] resp1_bits;
  logic        tl_in_valid, tl_in_ready;
  logic [31:0] tl_in_bits;
  logic        tl_out_valid, tl_out_ready;
  logic [31:0] tl_out_bits;
  logic        busy;
  logic [3:0]  outstanding;

  beat_t       q_req0[$];
  beat_t       q_req1[$];
  logic [31:0] q_tlo[$];
  logic [31:0] q_exp_tlin[$];
  logic [31:0] q_obs_tlin[$];
  logic [33:0] q_exp_resp[$];  // {port, last, bits}
  logic [33:0] q_obs_resp[$];

  int n_checks;
  int n_fail;

  serial_tl_arbiter #(.OWNER_DEPTH(Depth)) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_bits    (req0_bits),
    .req0_last    (req0_last),
    .req0_rlen    (req0_rlen),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_bits    (req1_bits),
    .req1_last    (req1_last),
    .req1_rlen    (req1_rlen),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_bits   (resp0_bits),
    .resp0_last   (resp0_last),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_bits   (resp1_bits),
    .resp1_last   (resp1_last),
    .tl_in_valid  (tl_in_valid),
    .tl_in_ready  (tl_in_ready),
    .tl_in_bits   (tl_in_bits),
    .tl_out_valid (tl_out_valid),
    .tl_out_ready (tl_out_ready),
    .tl_out_bits  (tl_out_bits),
    .busy         (busy),
    .outstanding  (outstanding)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive_inputs();
    beat_t b;
    if (q_req0.size() != 0) begin
      b = q_req0[0];
      req0_valid = 1'b1; req0_bits = b.bits; req0_last = b.last; req0_rlen = b.rlen;
    end else begin
      req0_valid = 1'b0; req0_bits = 32'd0; req0_last = 1'b0; req0_rlen = 4'd0;
    end
    if (q_req1.size() != 0) begin
      b = q_req1[0];
      req1_valid = 1'b1; req1_bits = b.bits; req1_last = b.last; req1_rlen = b.rlen;
    end else begin
      req1_valid = 1'b0; req1_bits = 32'd0; req1_last = 1'b0; req1_rlen = 4'd0;
    end
    if (q_tlo.size() != 0) begin
      tl_out_valid = 1'b1; tl_out_bits = q_tlo[0];
    end else begin
      tl_out_valid = 1'b0; tl_out_bits = 32'd0;
    end
  endtask

  // Capture handshakes mid-cycle, retire accepted stimulus after the edge, then re-drive.
  task automatic tick();
    logic f0, f1, ft;
    @(negedge clock);
    f0 = req0_valid && req0_ready;
    f1 = req1_valid && req1_ready;
    ft = tl_out_valid && tl_out_ready;
    if (tl_in_valid && tl_in_ready) q_obs_tlin.push_back(tl_in_bits);
    if (resp0_valid && resp0_ready) q_obs_resp.push_back({1'b0, resp0_last, resp0_bits});
    if (resp1_valid && resp1_ready) q_obs_resp.push_back({1'b1, resp1_last, resp1_bits});
    @(posedge clock);
    #1;
    if (f0) void'(q_req0.pop_front());
    if (f1) void'(q_req1.pop_front());
    if (ft) void'(q_tlo.pop_front());
    drive_inputs();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q_req0.delete(); q_req1.delete(); q_tlo.delete();
    tl_in_ready = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive_inputs();
    #1;
  endtask

  task automatic load_req(input bit port, input logic [31:0] base, input int n,
                          input logic [3:0] rlen);
    for (int i = 0; i < n; i++) begin
      if (port) q_req1.push_back('{bits: base + 32'(i), last: (i == n - 1), rlen: rlen});
      else      q_req0.push_back('{bits: base + 32'(i), last: (i == n - 1), rlen: rlen});
      q_exp_tlin.push_back(base + 32'(i));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_bits = 32'h1234_5678; req0_last = 1'b1; req0_rlen = 4'd2;
    req1_valid = 1'b1; req1_bits = 32'h8765_4321; req1_last = 1'b0; req1_rlen = 4'd1;
    tl_out_valid = 1'b1; tl_out_bits = 32'hDEAD_BEEF;
    tl_in_ready = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    @(posedge clock);
    #2;
    n_checks++;
    if ({tl_in_valid, req0_ready, req1_ready, tl_out_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_handshakes got=%b exp=0000",
               {tl_in_valid, req0_ready, req1_ready, tl_out_ready});
    end
    n_checks++;
    if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid_busy got=%b exp=000", {resp0_valid, resp1_valid, busy});
    end
    n_checks++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding);
    end
    n_checks++;
    if ({tl_in_bits, resp0_bits, resp1_bits} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_bits got=%h %h %h exp=0", tl_in_bits, resp0_bits, resp1_bits);
    end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [31:0] e32, o32;
    logic [33:0] e34, o34;
    do_reset();
    q_req0.push_back('{bits: 32'hA0, last: 1'b0, rlen: 4'd1});
    q_req0.push_back('{bits: 32'hA1, last: 1'b0, rlen: 4'd1});
    q_req0.push_back('{bits: 32'hA2, last: 1'b1, rlen: 4'd1});
    q_exp_tlin.push_back(32'hA0); q_exp_tlin.push_back(32'hA1); q_exp_tlin.push_back(32'hA2);
    drive_inputs();
    #1;
    n_checks++;
    if ({req0_ready, tl_in_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_grant_cycle got=%b exp=00", {req0_ready, tl_in_valid});
    end
    tick();
    n_checks++;
    if ({outstanding, tl_in_valid, req0_ready, tl_in_bits} !== {4'd1, 1'b1, 1'b1, 32'hA0}) begin
      n_fail++;
      $display("FAIL single_first_beat got=%0d %b %b %h exp=1 1 1 a0",
               outstanding, tl_in_valid, req0_ready, tl_in_bits);
    end
    repeat (3) tick();
    n_checks++;
    if (q_req0.size() != 0 || tl_in_valid !== 1'b0 || outstanding !== 4'd1) begin
      n_fail++;
      $display("FAIL single_req_done got=left%0d v%b occ%0d exp=left0 v0 occ1",
               q_req0.size(), tl_in_valid, outstanding);
    end
    q_tlo.push_back(32'hB0); q_tlo.push_back(32'hB1);
    q_exp_resp.push_back({1'b0, 1'b0, 32'hB0}); q_exp_resp.push_back({1'b0, 1'b1, 32'hB1});
    drive_inputs();
    #1;
    n_checks++;
    if ({resp0_valid, resp0_last, resp1_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL single_resp_route got=%b exp=100", {resp0_valid, resp0_last, resp1_valid});
    end
    tick();
    n_checks++;
    if (resp0_last !== 1'b1) begin
      n_fail++; $display("FAIL single_resp_last got=%b exp=1", resp0_last);
    end
    tick();
    n_checks++;
    if ({outstanding, busy} !== {4'd0, 1'b0}) begin
      n_fail++; $display("FAIL single_drained got=occ%0d busy%b exp=occ0 busy0", outstanding, busy);
    end
    n_checks++;
    if (q_obs_tlin.size() != q_exp_tlin.size() || q_obs_resp.size() != q_exp_resp.size()) begin
      n_fail++;
      $display("FAIL single_beat_counts got=%0d/%0d exp=%0d/%0d", q_obs_tlin.size(),
               q_obs_resp.size(), q_exp_tlin.size(), q_exp_resp.size());
    end
    while (q_exp_tlin.size() != 0 && q_obs_tlin.size() != 0) begin
      e32 = q_exp_tlin.pop_front(); o32 = q_obs_tlin.pop_front(); n_checks++;
      if (o32 !== e32) begin n_fail++; $display("FAIL single_tl_in got=%h exp=%h", o32, e32); end
    end
    while (q_exp_resp.size() != 0 && q_obs_resp.size() != 0) begin
      e34 = q_exp_resp.pop_front(); o34 = q_obs_resp.pop_front(); n_checks++;
      if (o34 !== e34) begin n_fail++; $display("FAIL single_resp got=%h exp=%h", o34, e34); end
    end
    q_exp_tlin.delete(); q_obs_tlin.delete(); q_exp_resp.delete(); q_obs_resp.delete();
  endtask

  task automatic test_round_robin();
    logic [31:0] e32, o32;
    logic [33:0] e34, o34;
    do_reset();
    load_req(1'b0, 32'hC0, 2, 4'd0);
    load_req(1'b1, 32'hD0, 2, 4'd0);
    drive_inputs();
    #1;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rr_first_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    for (int i = 0; i < 20 && (q_req0.size() + q_req1.size()) != 0; i++) tick();
    load_req(1'b0, 32'hE0, 1, 4'd0);
    load_req(1'b1, 32'hF0, 1, 4'd0);
    drive_inputs();
    #1;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rr_next_contention got=%b exp=10", {req0_ready, req1_ready});
    end
    for (int i = 0; i < 20 && (q_req0.size() + q_req1.size()) != 0; i++) tick();
    for (int i = 0; i < 4; i++) begin
      q_tlo.push_back(32'h100 + 32'(i));
      q_exp_resp.push_back({1'(i % 2), 1'b1, 32'h100 + 32'(i)});
    end
    drive_inputs();
    for (int i = 0; i < 30 && outstanding != 4'd0; i++) tick();
    n_checks++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL rr_drain got=%0d exp=0", outstanding);
    end
    n_checks++;
    if (q_obs_tlin.size() != q_exp_tlin.size() || q_obs_resp.size() != q_exp_resp.size()) begin
      n_fail++;
      $display("FAIL rr_beat_counts got=%0d/%0d exp=%0d/%0d", q_obs_tlin.size(),
               q_obs_resp.size(), q_exp_tlin.size(), q_exp_resp.size());
    end
    while (q_exp_tlin.size() != 0 && q_obs_tlin.size() != 0) begin
      e32 = q_exp_tlin.pop_front(); o32 = q_obs_tlin.pop_front(); n_checks++;
      if (o32 !== e32) begin n_fail++; $display("FAIL rr_tl_in got=%h exp=%h", o32, e32); end
    end
    while (q_exp_resp.size() != 0 && q_obs_resp.size() != 0) begin
      e34 = q_exp_resp.pop_front(); o34 = q_obs_resp.pop_front(); n_checks++;
      if (o34 !== e34) begin n_fail++; $display("FAIL rr_resp got=%h exp=%h", o34, e34); end
    end
    q_exp_tlin.delete(); q_obs_tlin.delete(); q_exp_resp.delete(); q_obs_resp.delete();
  endtask

  task automatic test_fifo_full();
    logic [31:0] e32, o32;
    logic [33:0] e34, o34;
    do_reset();
    for (int i = 0; i < 5; i++) load_req(1'b0, 32'h200 + 32'(i), 1, 4'd0);
    drive_inputs();
    #1;
    repeat (8) tick();
    n_checks++;
    if (outstanding !== 4'd4 || q_req0.size() != 1) begin
      n_fail++;
      $display("FAIL full_occupancy got=occ%0d left%0d exp=occ4 left1", outstanding, q_req0.size());
    end
    repeat (3) tick();
    n_checks++;
    if ({req0_ready, tl_in_valid} !== 2'b00 || outstanding !== 4'd4 || q_req0.size() != 1) begin
      n_fail++;
      $display("FAIL full_holds got=rdy%b v%b occ%0d left%0d exp=rdy0 v0 occ4 left1",
               req0_ready, tl_in_valid, outstanding, q_req0.size());
    end
    q_tlo.push_back(32'h300);
    q_exp_resp.push_back({1'b0, 1'b1, 32'h300});
    drive_inputs();
    #1;
    n_checks++;
    if ({resp0_valid, resp0_last} !== 2'b11) begin
      n_fail++; $display("FAIL full_resp got=%b exp=11", {resp0_valid, resp0_last});
    end
    tick();
    n_checks++;
    if (outstanding !== 4'd3 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after_pop got=occ%0d rdy%b exp=occ3 rdy0", outstanding, req0_ready);
    end
    tick();
    n_checks++;
    if ({outstanding, req0_ready, tl_in_bits} !== {4'd4, 1'b1, 32'h204}) begin
      n_fail++;
      $display("FAIL full_fifth_grant got=occ%0d rdy%b %h exp=occ4 rdy1 204",
               outstanding, req0_ready, tl_in_bits);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      q_tlo.push_back(32'h310 + 32'(i));
      q_exp_resp.push_back({1'b0, 1'b1, 32'h310 + 32'(i)});
    end
    drive_inputs();
    for (int i = 0; i < 30 && outstanding != 4'd0; i++) tick();
    n_checks++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL full_drain got=%0d exp=0", outstanding);
    end
    n_checks++;
    if (q_obs_tlin.size() != q_exp_tlin.size() || q_obs_resp.size() != q_exp_resp.size()) begin
      n_fail++;
      $display("FAIL full_beat_counts got=%0d/%0d exp=%0d/%0d", q_obs_tlin.size(),
               q_obs_resp.size(), q_exp_tlin.size(), q_exp_resp.size());
    end
    while (q_exp_tlin.size() != 0 && q_obs_tlin.size() != 0) begin
      e32 = q_exp_tlin.pop_front(); o32 = q_obs_tlin.pop_front(); n_checks++;
      if (o32 !== e32) begin n_fail++; $display("FAIL full_tl_in got=%h exp=%h", o32, e32); end
    end
    while (q_exp_resp.size() != 0 && q_obs_resp.size() != 0) begin
      e34 = q_exp_resp.pop_front(); o34 = q_obs_resp.pop_front(); n_checks++;
      if (o34 !== e34) begin n_fail++; $display("FAIL full_resp got=%h exp=%h", o34, e34); end
    end
    q_exp_tlin.delete(); q_obs_tlin.delete(); q_exp_resp.delete(); q_obs_resp.delete();
  endtask

  task automatic test_push_pop();
    logic [31:0] e32, o32;
    logic [33:0] e34, o34;
    do_reset();
    load_req(1'b1, 32'h400, 1, 4'd0);
    drive_inputs();
    #1;
    repeat (2) tick();
    load_req(1'b0, 32'h401, 1, 4'd0);
    drive_inputs();
    #1;
    repeat (2) tick();
    n_checks++;
    if (outstanding !== 4'd2) begin
      n_fail++; $display("FAIL pp_setup got=%0d exp=2", outstanding);
    end
    load_req(1'b1, 32'h402, 1, 4'd0);
    q_tlo.push_back(32'h500);
    q_exp_resp.push_back({1'b1, 1'b1, 32'h500});
    drive_inputs();
    #1;
    n_checks++;
    if ({resp1_valid, resp1_last, resp0_valid, tl_out_ready} !== 4'b1101) begin
      n_fail++;
      $display("FAIL pp_head_route got=%b exp=1101",
               {resp1_valid, resp1_last, resp0_valid, tl_out_ready});
    end
    tick();
    n_checks++;
    if (outstanding !== 4'd2 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_same_cycle got=occ%0d rdy1=%b exp=occ2 rdy1=1", outstanding, req1_ready);
    end
    tick();
    q_tlo.push_back(32'h501); q_tlo.push_back(32'h502);
    q_exp_resp.push_back({1'b0, 1'b1, 32'h501}); q_exp_resp.push_back({1'b1, 1'b1, 32'h502});
    drive_inputs();
    for (int i = 0; i < 30 && outstanding != 4'd0; i++) tick();
    n_checks++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL pp_drain got=%0d exp=0", outstanding);
    end
    n_checks++;
    if (q_obs_tlin.size() != q_exp_tlin.size() || q_obs_resp.size() != q_exp_resp.size()) begin
      n_fail++;
      $display("FAIL pp_beat_counts got=%0d/%0d exp=%0d/%0d", q_obs_tlin.size(),
               q_obs_resp.size(), q_exp_tlin.size(), q_exp_resp.size());
    end
    while (q_exp_tlin.size() != 0 && q_obs_tlin.size() != 0) begin
      e32 = q_exp_tlin.pop_front(); o32 = q_obs_tlin.pop_front(); n_checks++;
      if (o32 !== e32) begin n_fail++; $display("FAIL pp_tl_in got=%h exp=%h", o32, e32); end
    end
    while (q_exp_resp.size() != 0 && q_obs_resp.size() != 0) begin
      e34 = q_exp_resp.pop_front(); o34 = q_obs_resp.pop_front(); n_checks++;
      if (o34 !== e34) begin n_fail++; $display("FAIL pp_resp got=%h exp=%h", o34, e34); end
    end
    q_exp_tlin.delete(); q_obs_tlin.delete(); q_exp_resp.delete(); q_obs_resp.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] e32, o32;
    logic [33:0] e34, o34;
    do_reset();
    load_req(1'b0, 32'h600, 1, 4'd3);
    drive_inputs();
    #1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      q_tlo.push_back(32'h700 + 32'(i));
      q_exp_resp.push_back({1'b0, (i == 3), 32'h700 + 32'(i)});
    end
    drive_inputs();
    #1;
    tick();
    resp0_ready = 1'b0;
    #1;
    n_checks++;
    if ({tl_out_ready, resp0_valid, resp0_bits} !== {1'b0, 1'b1, 32'h701}) begin
      n_fail++;
      $display("FAIL bp_stall_start got=%b %b %h exp=0 1 701", tl_out_ready, resp0_valid,
               resp0_bits);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (tl_out_ready !== 1'b0 || resp0_last !== 1'b0 || q_tlo.size() != 3) begin
        n_fail++;
        $display("FAIL bp_stall got=rdy%b last%b left%0d exp=rdy0 last0 left3",
                 tl_out_ready, resp0_last, q_tlo.size());
      end
    end
    resp0_ready = 1'b1;
    #1;
    for (int i = 0; i < 20 && outstanding != 4'd0; i++) tick();
    n_checks++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL bp_drain got=%0d exp=0", outstanding);
    end
    n_checks++;
    if (q_obs_tlin.size() != q_exp_tlin.size() || q_obs_resp.size() != q_exp_resp.size()) begin
      n_fail++;
      $display("FAIL bp_beat_counts got=%0d/%0d exp=%0d/%0d", q_obs_tlin.size(),
               q_obs_resp.size(), q_exp_tlin.size(), q_exp_resp.size());
    end
    while (q_exp_tlin.size() != 0 && q_obs_tlin.size() != 0) begin
      e32 = q_exp_tlin.pop_front(); o32 = q_obs_tlin.pop_front(); n_checks++;
      if (o32 !== e32) begin n_fail++; $display("FAIL bp_tl_in got=%h exp=%h", o32, e32); end
    end
    while (q_exp_resp.size() != 0 && q_obs_resp.size() != 0) begin
      e34 = q_exp_resp.pop_front(); o34 = q_obs_resp.pop_front(); n_checks++;
      if (o34 !== e34) begin n_fail++; $display("FAIL bp_resp got=%h exp=%h", o34, e34); end
    end
    q_exp_tlin.delete(); q_obs_tlin.delete(); q_exp_resp.delete(); q_obs_resp.delete();
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] e32, o32;
    logic [33:0] e34, o34;
    do_reset();
    q_req1.push_back('{bits: 32'h800, last: 1'b0, rlen: 4'd0});
    q_req1.push_back('{bits: 32'h801, last: 1'b0, rlen: 4'd0});
    q_req1.push_back('{bits: 32'h802, last: 1'b1, rlen: 4'd0});
    q_exp_tlin.push_back(32'h800);
    drive_inputs();
    #1;
    repeat (2) tick();
    n_checks++;
    if ({req1_ready, tl_in_bits} !== {1'b1, 32'h801}) begin
      n_fail++; $display("FAIL mid_in_packet got=%b %h exp=1 801", req1_ready, tl_in_bits);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tl_in_valid, req0_ready, req1_ready, busy, outstanding, tl_in_bits} !== 40'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got=v%b r%b%b busy%b occ%0d %h exp=0",
               tl_in_valid, req0_ready, req1_ready, busy, outstanding, tl_in_bits);
    end
    do_reset();
    load_req(1'b0, 32'h900, 1, 4'd0);
    load_req(1'b1, 32'h901, 1, 4'd0);
    drive_inputs();
    #1;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mid_first_contention got=%b exp=10", {req0_ready, req1_ready});
    end
    for (int i = 0; i < 20 && (q_req0.size() + q_req1.size()) != 0; i++) tick();
    q_tlo.push_back(32'hA00); q_tlo.push_back(32'hA01);
    q_exp_resp.push_back({1'b0, 1'b1, 32'hA00}); q_exp_resp.push_back({1'b1, 1'b1, 32'hA01});
    drive_inputs();
    for (int i = 0; i < 20 && outstanding != 4'd0; i++) tick();
    n_checks++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL mid_drain got=%0d exp=0", outstanding);
    end
    n_checks++;
    if (q_obs_tlin.size() != q_exp_tlin.size() || q_obs_resp.size() != q_exp_resp.size()) begin
      n_fail++;
      $display("FAIL mid_beat_counts got=%0d/%0d exp=%0d/%0d", q_obs_tlin.size(),
               q_obs_resp.size(), q_exp_tlin.size(), q_exp_resp.size());
    end
    while (q_exp_tlin.size() != 0 && q_obs_tlin.size() != 0) begin
      e32 = q_exp_tlin.pop_front(); o32 = q_obs_tlin.pop_front(); n_checks++;
      if (o32 !== e32) begin n_fail++; $display("FAIL mid_tl_in got=%h exp=%h", o32, e32); end
    end
    while (q_exp_resp.size() != 0 && q_obs_resp.size() != 0) begin
      e34 = q_exp_resp.pop_front(); o34 = q_obs_resp.pop_front(); n_checks++;
      if (o34 !== e34) begin n_fail++; $display("FAIL mid_resp got=%h exp=%h", o34, e34); end
    end
    q_exp_tlin.delete(); q_obs_tlin.delete(); q_exp_resp.delete(); q_obs_resp.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    tl_in_ready = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    drive_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_fifo_full();
    test_push_pop();
    test_backpressure();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
